// File: rtl/sched_gmii_sender.sv
// Time-scheduled GMII transmitter: pulls slot records from a ring buffer and sends each frame with
// preamble and CRC-32 at its target time. Define SENDER_PAD_EN to zero-pad short frames to 60 bytes.
module sched_gmii_sender #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned N_LOCAL    = 7,
  parameter int unsigned IFG_CYCLES = 12,
  parameter int unsigned MAX_LEN    = 1518
) (
  input  logic                  gmii_tx_clk,
  input  logic                  sys_rst,
  input  logic [63:0]           global_counter,
  output logic [7:0]            gmii_txd,
  output logic                  gmii_tx_en,
  output logic [ADDR_W-1:0]     slot_rd_addr,
  input  logic [15:0]           slot_rd_q,
  input  logic [ADDR_W-1:0]     mem_wr_ptr,
  output logic [ADDR_W-1:0]     mem_rd_ptr,
  input  logic [48*N_LOCAL-1:0] local_time,
  output logic [N_LOCAL-1:0]    local_time_req,
  output logic [31:0]           tx_frame_cnt,
  output logic [31:0]           tx_late_cnt,
  output logic                  tx_busy
);

`ifdef SENDER_PAD_EN
  typedef enum logic [2:0] {StIdle, StHdr, StWait, StPre, StData, StPad, StFcs, StIfg} state_e;
`else
  typedef enum logic [2:0] {StIdle, StHdr, StWait, StPre, StData, StFcs, StIfg} state_e;
`endif

  state_e              state_q;
  logic [15:0]         idx_q;
  logic [ADDR_W-1:0]   start_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [15:0]         len_q;
  logic [63:0]         ts_q;
  logic [47:0]         target_q;
  logic [7:0]          lo_q;
  logic [31:0]         crc_q;
  logic [7:0]          txd_q;
  logic                en_q;
  logic [N_LOCAL-1:0]  req_q;
  logic [31:0]         frame_cnt_q;
  logic [31:0]         late_cnt_q;

  logic [47:0]         offset;
  logic [2:0]          sel;
  logic                sel_ok;
  logic                drop;
  logic                due;
  logic                late;
  logic [16:0]         rec_words;
  logic [ADDR_W-1:0]   end_ptr;
  logic [31:0]         fcs;
  logic [7:0]          fcs_next;
  logic                unused_gc_hi;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign sel    = ts_q[62:60];
  assign sel_ok = (sel != 3'd0) && (32'(sel) <= N_LOCAL);

  // Selector values outside 1..N_LOCAL fall back to a zero offset.
  always_comb begin
    offset = '0;
    for (int unsigned k = 0; k < N_LOCAL; k++) begin
      if (sel == 3'(k + 1)) offset = local_time[48*k +: 48];
    end
  end

  assign rec_words = 17'd7 + ((17'(len_q) + 17'd1) >> 1);
  assign end_ptr   = start_q + ADDR_W'(rec_words);
  assign drop      = (len_q == 16'd0) || (32'(len_q) > MAX_LEN);
  assign due       = ts_q[63] || (ts_q[47:0] == 48'd0) || (global_counter[47:0] >= target_q);
  assign late      = !ts_q[63] && (ts_q[47:0] != 48'd0) && (global_counter[47:0] > target_q);
  assign fcs       = ~crc_q;
  assign fcs_next  = fcs[{idx_q[1:0] + 2'd1, 3'b000} +: 8];
  assign unused_gc_hi = ^global_counter[63:48];

  always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      start_q     <= '0;
      addr_q      <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      ts_q        <= '0;
      target_q    <= '0;
      lo_q        <= '0;
      crc_q       <= '1;
      txd_q       <= '0;
      en_q        <= 1'b0;
      req_q       <= '0;
      frame_cnt_q <= '0;
      late_cnt_q  <= '0;
    end else begin
      req_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (rd_ptr_q != mem_wr_ptr) begin
            state_q <= StHdr;
            idx_q   <= '0;
            start_q <= rd_ptr_q;
            addr_q  <= rd_ptr_q;
          end
        end
        StHdr: begin
          // Word n arrives one cycle after its address; idx 8 folds in the local offset.
          idx_q <= idx_q + 16'd1;
          if (idx_q < 16'd7) addr_q <= addr_q + ADDR_W'(1);
          case (idx_q)
            16'd1: len_q        <= slot_rd_q;
            16'd2: ts_q[63:48]  <= slot_rd_q;
            16'd3: ts_q[47:32]  <= slot_rd_q;
            16'd4: ts_q[31:16]  <= slot_rd_q;
            16'd5: ts_q[15:0]   <= slot_rd_q;
            16'd8: begin
              target_q <= ts_q[47:0] + offset;
              state_q  <= StWait;
              idx_q    <= '0;
            end
            default: ;
          endcase
        end
        StWait: begin
          if (drop) begin
            rd_ptr_q <= end_ptr;
            state_q  <= StIdle;
          end else if (due) begin
            state_q <= StPre;
            idx_q   <= '0;
            txd_q   <= 8'h55;
            en_q    <= 1'b1;
            crc_q   <= '1;
            if (late) late_cnt_q <= late_cnt_q + 32'd1;
            if (ts_q[63] && sel_ok) req_q <= N_LOCAL'(1) << (sel - 3'd1);
          end
        end
        StPre: begin
          idx_q <= idx_q + 16'd1;
          if (idx_q == 16'd7) begin
            state_q <= StData;
            idx_q   <= '0;
            txd_q   <= slot_rd_q[15:8];
            lo_q    <= slot_rd_q[7:0];
            addr_q  <= addr_q + ADDR_W'(1);
            crc_q   <= crc_byte(crc_q, slot_rd_q[15:8]);
          end else if (idx_q == 16'd6) begin
            txd_q <= 8'hD5;
          end else begin
            txd_q <= 8'h55;
          end
        end
        StData: begin
          if (idx_q + 16'd1 < len_q) begin
            idx_q <= idx_q + 16'd1;
            // Even byte positions open a new word; the address runs one word ahead of the wire.
            if (idx_q[0]) begin
              txd_q  <= slot_rd_q[15:8];
              lo_q   <= slot_rd_q[7:0];
              addr_q <= addr_q + ADDR_W'(1);
              crc_q  <= crc_byte(crc_q, slot_rd_q[15:8]);
            end else begin
              txd_q <= lo_q;
              crc_q <= crc_byte(crc_q, lo_q);
            end
`ifdef SENDER_PAD_EN
          end else if (len_q < 16'd60) begin
            state_q <= StPad;
            idx_q   <= idx_q + 16'd1;
            txd_q   <= 8'h00;
            crc_q   <= crc_byte(crc_q, 8'h00);
`endif
          end else begin
            state_q <= StFcs;
            idx_q   <= '0;
            txd_q   <= fcs[7:0];
          end
        end
`ifdef SENDER_PAD_EN
        StPad: begin
          if (idx_q + 16'd1 < 16'd60) begin
            idx_q <= idx_q + 16'd1;
            txd_q <= 8'h00;
            crc_q <= crc_byte(crc_q, 8'h00);
          end else begin
            state_q <= StFcs;
            idx_q   <= '0;
            txd_q   <= fcs[7:0];
          end
        end
`endif
        StFcs: begin
          idx_q <= idx_q + 16'd1;
          if (idx_q == 16'd3) begin
            state_q <= StIfg;
            idx_q   <= '0;
            en_q    <= 1'b0;
            txd_q   <= 8'h00;
          end else begin
            txd_q <= fcs_next;
            if (idx_q == 16'd2) begin
              rd_ptr_q    <= end_ptr;
              frame_cnt_q <= frame_cnt_q + 32'd1;
            end
          end
        end
        StIfg: begin
          if (idx_q == 16'(IFG_CYCLES - 1)) state_q <= StIdle;
          else idx_q <= idx_q + 16'd1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gmii_txd       = txd_q;
  assign gmii_tx_en     = en_q;
  assign slot_rd_addr   = addr_q;
  assign mem_rd_ptr     = rd_ptr_q;
  assign local_time_req = req_q;
  assign tx_frame_cnt   = frame_cnt_q;
  assign tx_late_cnt    = late_cnt_q;
  assign tx_busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sched_gmii_sender.sv
// Directed bench for sched_gmii_sender: slot memory model, wire capture and hand-derived checks.
module tb_sched_gmii_sender;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   cyc = '0;
  logic [63:0]   off = '0;
  logic [63:0]   gcnt;
  logic [7:0]    txd;
  logic          en;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [335:0]  ltime;
  logic [6:0]    req;
  logic [31:0]   fcnt;
  logic [31:0]   lcnt;
  logic          busy;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic [7:0]    cap[$];
  logic [7:0]    exp_q[$];
  int            rises, idle_bad, req_cnt;
  logic [6:0]    req_val;
  logic [63:0]   rise_cyc, rise_gc, c0;
  logic          en_prev = 1'b0;
  int            total = 0;
  int            bad = 0;
  int            nframes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 64'd1;
  always @(posedge clk) rd_q <= mem[rd_addr];
  assign gcnt = cyc + off;

  sched_gmii_sender dut (
    .gmii_tx_clk   (clk),
    .sys_rst       (rst),
    .global_counter(gcnt),
    .gmii_txd      (txd),
    .gmii_tx_en    (en),
    .slot_rd_addr  (rd_addr),
    .slot_rd_q     (rd_q),
    .mem_wr_ptr    (wr_ptr),
    .mem_rd_ptr    (rd_ptr),
    .local_time    (ltime),
    .local_time_req(req),
    .tx_frame_cnt  (fcnt),
    .tx_late_cnt   (lcnt),
    .tx_busy       (busy)
  );

  always @(negedge clk) begin
    if (rst) begin
      en_prev = 1'b0;
    end else begin
      if (en) begin
        cap.push_back(txd);
        if (!en_prev) begin
          rises++;
          rise_cyc = cyc;
          rise_gc  = gcnt;
        end
      end else if (txd != 8'h00) begin
        idle_bad++;
      end
      if (req != '0) begin
        req_cnt++;
        req_val = req;
      end
      en_prev = en;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [7:0] pay(input logic [7:0] base, input logic [7:0] step, input int i);
    return 8'(int'(base) + int'(step) * i);
  endfunction

  // Writes one slot record and builds the expected wire byte stream for it.
  task automatic send(input logic [AW-1:0] start, input logic [15:0] len, input logic [63:0] ts,
                      input logic [7:0] base, input logic [7:0] step, output logic [AW-1:0] nxt);
    logic [AW-1:0] a;
    logic [7:0]    hi, lo, b;
    logic [31:0]   c;
    int            nw, n;
    nw = (int'(len) + 1) / 2;
    a = start;
    mem[a]         = len;
    mem[a + 14'd1] = ts[63:48];
    mem[a + 14'd2] = ts[47:32];
    mem[a + 14'd3] = ts[31:16];
    mem[a + 14'd4] = ts[15:0];
    mem[a + 14'd5] = 16'hBEEF;
    mem[a + 14'd6] = 16'hCAFE;
    for (int w = 0; w < nw; w++) begin
      hi = pay(base, step, 2 * w);
      lo = (2 * w + 1 < int'(len)) ? pay(base, step, 2 * w + 1) : 8'h00;
      mem[a + 14'd7 + 14'(w)] = {hi, lo};
    end
    nxt = start + 14'(7 + nw);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    n = int'(len);
`ifdef SENDER_PAD_EN
    if (n < 60) n = 60;
`endif
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      b = (i < int'(len)) ? pay(base, step, i) : 8'h00;
      exp_q.push_back(b);
      c = crc_ref(c, b);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  task automatic arm();
    @(posedge clk);
    cap.delete();
    rises    = 0;
    idle_bad = 0;
    req_cnt  = 0;
    req_val  = '0;
  endtask

  task automatic go(input logic [AW-1:0] wp, input bit set_gc, input logic [63:0] gc_val);
    bit done;
    arm();
    @(negedge clk);
    if (set_gc) off = gc_val - cyc;
    wr_ptr = wp;
    c0 = cyc;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      if (!busy && rd_ptr == wr_ptr) done = 1'b1;
    end
    check("done", 64'(done), 64'd1);
  endtask

  task automatic check_frame(input string tag);
    int nerr;
    nerr = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= cap.size()) nerr++;
      else if (cap[i] !== exp_q[i]) nerr++;
    end
    check({tag, "_size"}, 64'(cap.size()), 64'(exp_q.size()));
    check({tag, "_bytes"}, 64'(nerr), 64'd0);
    check({tag, "_rises"}, 64'(rises), 64'd1);
    check({tag, "_idle_txd"}, 64'(idle_bad), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] p, q;
    logic [63:0]   pre;
    logic [31:0]   fcs_w;
    int            n;

    rst = 1'b1;
    wr_ptr = '0;
    for (int k = 0; k < 7; k++) ltime[48*k +: 48] = 48'(7000 + k);
    ltime[48 +: 48] = 48'd500;
    repeat (3) @(negedge clk);
    check("rst_en", 64'(en), 64'd0);
    check("rst_txd", 64'(txd), 64'd0);
    check("rst_rdptr", 64'(rd_ptr), 64'd0);
    check("rst_rdaddr", 64'(rd_addr), 64'd0);
    check("rst_req", 64'(req), 64'd0);
    check("rst_fcnt", 64'(fcnt), 64'd0);
    check("rst_lcnt", 64'(lcnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // 64-byte immediate frame straight out of reset: no IFG ahead of it.
    send(14'd0, 16'd64, 64'd0, 8'h00, 8'h01, p);
    go(p, 1'b0, 64'd0);
    nframes++;
    check_frame("a");
    pre = '0;
    if (cap.size() >= 8) for (int i = 0; i < 8; i++) pre = {pre[55:0], cap[i]};
    check("a_preamble", pre, 64'h5555_5555_5555_55D5);
    check("a_latency", rise_cyc - c0, 64'd11);
    check("a_rdptr", 64'(rd_ptr), 64'd39);
    check("a_fcnt", 64'(fcnt), 64'd1);
    check("a_lcnt", 64'(lcnt), 64'd0);

    // Scheduled at 1000 + local_time[1] = 1500, queued well before.
    send(p, 16'd20, {1'b0, 3'd2, 12'd0, 48'd1000}, 8'h10, 8'h05, q);
    go(q, 1'b1, 64'd1400);
    nframes++;
    check_frame("b");
    check("b_start_gc", rise_gc, 64'd1501);
    check("b_lcnt", 64'(lcnt), 64'd0);
    check("b_rdptr", 64'(rd_ptr), 64'd56);

    // Same record queued after its target: sent at once, counted late.
    send(q, 16'd20, {1'b0, 3'd2, 12'd0, 48'd1000}, 8'h10, 8'h05, p);
    go(p, 1'b1, 64'd2000);
    nframes++;
    check_frame("c");
    check("c_latency", rise_cyc - c0, 64'd11);
    check("c_lcnt", 64'(lcnt), 64'd1);
    check("c_fcnt", 64'(fcnt), 64'(nframes));

`ifndef SENDER_PAD_EN
    // "123456789" has the well-known CRC-32 check value CBF43926.
    send(p, 16'd9, 64'd0, 8'h31, 8'h01, q);
    go(q, 1'b0, 64'd0);
    nframes++;
    n = cap.size();
    fcs_w = '0;
    if (n >= 4) fcs_w = {cap[n-1], cap[n-2], cap[n-3], cap[n-4]};
    check("crc_check_value", 64'(fcs_w), 64'h0000_0000_CBF4_3926);
    check("crc_frame_size", 64'(n), 64'd21);
    p = q;
`endif

    // Short odd-length frame: 17 data bytes (60 when padding is built in).
    send(p, 16'd17, 64'd0, 8'hA0, 8'h03, q);
    go(q, 1'b0, 64'd0);
    nframes++;
    check_frame("d");
    check("d_rdptr_step", 64'(rd_ptr - p), 64'd16);
    check("d_fcnt", 64'(fcnt), 64'(nframes));

    // Immediate start with resync request on selector 3, then reset mid-DATA.
    send(q, 16'd40, {1'b1, 3'd3, 60'd0}, 8'h00, 8'h07, p);
    arm();
    @(negedge clk);
    wr_ptr = p;
    for (int i = 0; i < 200 && rises == 0; i++) @(negedge clk);
    check("f_started", 64'(rises), 64'd1);
    repeat (12) @(negedge clk);
    check("f_req_cnt", 64'(req_cnt), 64'd1);
    check("f_req_val", 64'(req_val), 64'b0000100);
    check("f_en_before_rst", 64'(en), 64'd1);
    rst = 1'b1;
    wr_ptr = '0;
    #1;
    check("f_rst_en", 64'(en), 64'd0);
    check("f_rst_txd", 64'(txd), 64'd0);
    check("f_rst_rdptr", 64'(rd_ptr), 64'd0);
    check("f_rst_busy", 64'(busy), 64'd0);
    check("f_rst_fcnt", 64'(fcnt), 64'd0);
    check("f_rst_lcnt", 64'(lcnt), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Two oversized records: the second straddles the top of the ring and wraps.
    send(14'h3FF0, 16'd2000, 64'd0, 8'h00, 8'h01, q);
    send(14'h0000, 16'd32722, 64'd0, 8'h00, 8'h01, p);
    check("e_first_end", 64'(p), 64'h3FF0);
    go(q, 1'b0, 64'd0);
    check("e_no_tx", 64'(rises), 64'd0);
    check("e_rdptr", 64'(rd_ptr), 64'h03DF);
    check("e_fcnt", 64'(fcnt), 64'd0);
    check("e_lcnt", 64'(lcnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
